// File: rtl/ysyx_22050019_wbu.sv
// Writeback unit: arbitrates EXU/LSU results, formats loads, drives the GPR write port
// one cycle later and tracks per-register pending writes for decode hazard stalls.
module ysyx_22050019_wbu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic [DATA_WIDTH-1:0] exu_pc,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_raw,
  input  logic [2:0]            lsu_off,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [DATA_WIDTH-1:0] lsu_pc,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic [31:0]           busy,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc
);

  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [2:0]            off,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    fmt_load = {{(DATA_WIDTH-8){sh[7] & ~uns}}, sh[7:0]};
      2'd1:    fmt_load = {{(DATA_WIDTH-16){sh[15] & ~uns}}, sh[15:0]};
      2'd2:    fmt_load = {{(DATA_WIDTH-32){sh[31] & ~uns}}, sh[31:0]};
      default: fmt_load = sh;
    endcase
  endfunction

  logic                  w_take_lsu_p0;
  logic                  w_take_exu_p0;
  logic [DATA_WIDTH-1:0] w_load_p0;
  logic [31:0]           w_set;
  logic [31:0]           w_clr;

  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_rd_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic [DATA_WIDTH-1:0] r_pc_p1;
  logic [31:0]           r_busy;

  // Stage p0: fixed-priority acceptance, LSU wins
  assign lsu_ready     = 1'b1;
  assign exu_ready     = !lsu_valid;
  assign w_take_lsu_p0 = lsu_valid;
  assign w_take_exu_p0 = exu_valid && !lsu_valid;
  assign w_load_p0     = fmt_load(lsu_raw, lsu_off, lsu_size, lsu_unsigned);

  // Stage p1: output register, drained every cycle since the register file never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_rd_p1   <= '0;
      r_data_p1 <= '0;
      r_pc_p1   <= '0;
    end else begin
      r_vld_p1 <= w_take_lsu_p0 || w_take_exu_p0;
      if (w_take_lsu_p0) begin
        r_rd_p1   <= lsu_rd;
        r_data_p1 <= w_load_p0;
        r_pc_p1   <= lsu_pc;
      end else if (w_take_exu_p0) begin
        r_rd_p1   <= exu_rd;
        r_data_p1 <= exu_data;
        r_pc_p1   <= exu_pc;
      end
    end
  end

  assign wen          = r_vld_p1 && (r_rd_p1 != '0);
  assign waddr        = r_rd_p1;
  assign wdata        = r_data_p1;
  assign commit_valid = r_vld_p1;
  assign commit_pc    = r_pc_p1;

  // Scoreboard: a new producer's set overrides the retiring write's clear; x0 never pends
  assign w_set = iss_valid ? (32'd1 << iss_rd) : 32'd0;
  assign w_clr = wen ? (32'd1 << waddr) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_ysyx_22050019_wbu.sv
// Bench for ysyx_22050019_wbu: directed scenarios followed by random traffic checked
// against a transaction-level model of acceptance, load formatting and the scoreboard.
module tb_ysyx_22050019_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data, exu_pc;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_raw;
  logic [2:0]  lsu_off;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [63:0] lsu_pc;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: what the DUT should be presenting now, plus pending-write flags
  logic        m_vld;
  logic [4:0]  m_rd;
  logic [63:0] m_data, m_pc;
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  ysyx_22050019_wbu #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
    .exu_data(exu_data), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_raw(lsu_raw), .lsu_off(lsu_off), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_pc(lsu_pc),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // byte-wise gather of the accessed bytes, then sign extension by arithmetic
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input int off,
                                           input int size, input logic uns);
    int nb;
    logic [63:0] v;
    nb = 1 << size;
    v  = 64'd0;
    for (int j = 0; j < nb; j++)
      if (off + j < 8) v = v | (((raw >> (8 * (off + j))) & 64'hFF) << (8 * j));
    if (!uns && nb < 8 && v[8 * nb - 1]) v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  task automatic idle();
    exu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_rd = 5'd0; m_data = 64'd0; m_pc = 64'd0; m_busy = 32'd0;
  endtask

  task automatic model_edge();
    if (m_vld && m_rd != 5'd0) m_busy[m_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (lsu_valid) begin
      m_vld = 1'b1; m_rd = lsu_rd; m_pc = lsu_pc;
      m_data = ref_load(lsu_raw, int'(lsu_off), int'(lsu_size), lsu_unsigned);
    end else if (exu_valid) begin
      m_vld = 1'b1; m_rd = exu_rd; m_data = exu_data; m_pc = exu_pc;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exu(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    exu_valid = 1'b1; exu_rd = rd; exu_data = d; exu_pc = pc;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [63:0] raw, input logic [2:0] off,
                           input logic [1:0] sz, input logic uns, input logic [63:0] pc);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_raw = raw; lsu_off = off;
    lsu_size = sz; lsu_unsigned = uns; lsu_pc = pc;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wen"}, 64'(wen), 64'(m_vld && m_rd != 5'd0));
    chk({tag, ".commit_valid"}, 64'(commit_valid), 64'(m_vld));
    chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
    if (m_vld) begin
      chk({tag, ".waddr"}, 64'(waddr), 64'(m_rd));
      chk({tag, ".wdata"}, wdata, m_data);
      chk({tag, ".commit_pc"}, commit_pc, m_pc);
    end
  endtask

  initial begin
    bit pend;
    rst = 1'b1;
    idle();
    exu_rd = 5'd0; exu_data = 64'd0; exu_pc = 64'd0;
    lsu_rd = 5'd0; lsu_raw = 64'd0; lsu_off = 3'd0; lsu_size = 2'd0;
    lsu_unsigned = 1'b0; lsu_pc = 64'd0; iss_rd = 5'd0;
    model_reset();

    // reset state and arbitration during reset
    #1;
    chk("rst.wen", 64'(wen), 64'd0);
    chk("rst.commit_valid", 64'(commit_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.waddr", 64'(waddr), 64'd0);
    chk("rst.wdata", wdata, 64'd0);
    chk("rst.commit_pc", commit_pc, 64'd0);
    chk("rst.lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst.exu_ready_idle", 64'(exu_ready), 64'd1);
    lsu_valid = 1'b1;
    #1;
    chk("rst.exu_ready_lsu", 64'(exu_ready), 64'd0);
    lsu_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // single ALU writeback
    drive_exu(5'd5, 64'h1234, 64'h8000_0000);
    cyc();
    idle();
    chk("alu.wen", 64'(wen), 64'd1);
    chk("alu.waddr", 64'(waddr), 64'd5);
    chk("alu.wdata", wdata, 64'h1234);
    chk("alu.commit_valid", 64'(commit_valid), 64'd1);
    chk("alu.commit_pc", commit_pc, 64'h8000_0000);
    cyc();
    chk("alu.wen_after", 64'(wen), 64'd0);
    chk("alu.commit_after", 64'(commit_valid), 64'd0);

    // load formatting, back to back
    drive_lsu(5'd10, 64'h0000_0000_80FF_0000, 3'd2, 2'd0, 1'b0, 64'h100);
    cyc();
    chk("ld.lb", wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ld.lb_wen", 64'(wen), 64'd1);
    drive_lsu(5'd11, 64'h0000_0000_80FF_0000, 3'd2, 2'd1, 1'b1, 64'h104);
    cyc();
    chk("ld.lhu", wdata, 64'h80FF);
    chk("ld.lhu_waddr", 64'(waddr), 64'd11);
    drive_lsu(5'd12, 64'h0000_0000_80FF_0000, 3'd0, 2'd2, 1'b0, 64'h108);
    cyc();
    chk("ld.lw", wdata, 64'hFFFF_FFFF_80FF_0000);
    drive_lsu(5'd13, 64'h0000_0000_80FF_0000, 3'd0, 2'd3, 1'b0, 64'h10C);
    cyc();
    idle();
    chk("ld.ld", wdata, 64'h0000_0000_80FF_0000);
    chk("ld.ld_pc", commit_pc, 64'h10C);
    cyc();

    // simultaneous EXU and LSU: load first, ALU next cycle
    drive_exu(5'd3, 64'hAAAA, 64'h200);
    drive_lsu(5'd4, 64'h5555, 3'd0, 2'd3, 1'b0, 64'h204);
    #1;
    chk("arb.exu_ready", 64'(exu_ready), 64'd0);
    cyc();
    lsu_valid = 1'b0;
    chk("arb.first_waddr", 64'(waddr), 64'd4);
    chk("arb.first_wdata", wdata, 64'h5555);
    chk("arb.first_pc", commit_pc, 64'h204);
    #1;
    chk("arb.exu_ready_free", 64'(exu_ready), 64'd1);
    cyc();
    idle();
    chk("arb.second_wen", 64'(wen), 64'd1);
    chk("arb.second_waddr", 64'(waddr), 64'd3);
    chk("arb.second_wdata", wdata, 64'hAAAA);
    chk("arb.second_pc", commit_pc, 64'h200);
    cyc();
    chk("arb.drain", 64'(commit_valid), 64'd0);

    // write to x0 commits without writing; x0 never pends
    drive_exu(5'd0, 64'hDEAD, 64'h300);
    iss_valid = 1'b1; iss_rd = 5'd0;
    cyc();
    idle();
    chk("x0.wen", 64'(wen), 64'd0);
    chk("x0.commit_valid", 64'(commit_valid), 64'd1);
    chk("x0.commit_pc", commit_pc, 64'h300);
    chk("x0.busy", 64'(busy), 64'd0);
    cyc();

    // scoreboard: set, set-beats-clear, clear
    iss_valid = 1'b1; iss_rd = 5'd7;
    drive_exu(5'd7, 64'h77, 64'h400);
    cyc();
    exu_valid = 1'b0;
    chk("sb.set", 64'(busy[7]), 64'd1);
    chk("sb.wen7", 64'(wen && waddr == 5'd7), 64'd1);
    cyc();
    iss_valid = 1'b0;
    chk("sb.set_wins", 64'(busy[7]), 64'd1);
    drive_exu(5'd7, 64'h78, 64'h404);
    cyc();
    exu_valid = 1'b0;
    chk("sb.pending_during_wb", 64'(busy[7]), 64'd1);
    cyc();
    chk("sb.cleared", 64'(busy[7]), 64'd0);

    // reset while a result sits in the output register
    drive_exu(5'd9, 64'h99, 64'h500);
    iss_valid = 1'b1; iss_rd = 5'd12;
    cyc();
    idle();
    chk("mid.wen_before", 64'(wen), 64'd1);
    chk("mid.busy12_before", 64'(busy[12]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid.wen", 64'(wen), 64'd0);
    chk("mid.commit_valid", 64'(commit_valid), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.waddr", 64'(waddr), 64'd0);
    chk("mid.wdata", wdata, 64'd0);
    chk("mid.commit_pc", commit_pc, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();
    chk("mid.post_wen", 64'(wen), 64'd0);
    chk("mid.post_commit", 64'(commit_valid), 64'd0);
    chk("mid.post_busy", 64'(busy), 64'd0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      pend = exu_valid && lsu_valid;
      lsu_valid = ($urandom_range(0, 2) == 0);
      lsu_rd = 5'($urandom); lsu_raw = {$urandom, $urandom};
      lsu_off = 3'($urandom); lsu_size = 2'($urandom);
      lsu_unsigned = 1'($urandom); lsu_pc = {32'd0, $urandom};
      if (!pend) begin
        exu_valid = ($urandom_range(0, 1) == 1);
        exu_rd = 5'($urandom); exu_data = {$urandom, $urandom}; exu_pc = {32'd0, $urandom};
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = 5'($urandom);
      #1;
      chk("rnd.exu_ready", 64'(exu_ready), 64'(!lsu_valid));
      cyc();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
